// File: rtl/edge_tracker.sv
// Edge tracker: gradient pipeline, strongest-edge selection,
// debounce FSM and a one-entry valid/ready event register.
module edge_tracker #(
  parameter int NUM_PIXELS    = 5,
  parameter int PIXEL_WIDTH   = 8,
  parameter int THRESHOLD     = 16,
  parameter int CONFIRM_COUNT = 3,
  parameter int LOSS_COUNT    = 4
) (
  input  logic                              clock,
  input  logic                              resetN,
  input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] pixelsIn,
  input  logic                              pixelsValid,
  output logic                              edgeLocked,
  output logic [2:0]                        edgePosition,
  output logic [PIXEL_WIDTH-1:0]            edgeStrength,
  output logic                              eventValid,
  output logic [1:0]                        eventCode,
  output logic [2:0]                        eventPos,
  input  logic                              eventReady,
  output logic                              eventOverflow
);

  localparam int PW = PIXEL_WIDTH;
  localparam int NG = NUM_PIXELS - 1;
  localparam logic [PW-1:0] TH   = PW'(THRESHOLD);
  localparam logic [3:0]    CONF = 4'(CONFIRM_COUNT);
  localparam logic [3:0]    LOSS = 4'(LOSS_COUNT);
  localparam logic [1:0]    EV_LOCK = 2'd1;
  localparam logic [1:0]    EV_MOVE = 2'd2;
  localparam logic [1:0]    EV_LOSS = 2'd3;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_CAND,
    S_LOCKED
  } state_t;

  logic [PW-1:0] w_grad [NG];
  logic [PW-1:0] r_grad [NG];
  logic          r_s1Valid;
  logic [PW-1:0] w_max;
  logic [2:0]    w_idx;
  logic [PW-1:0] r_maxVal;
  logic [2:0]    r_maxIdx;
  logic          r_hit;
  logic          r_s2Valid;

  state_t        r_state, w_state;
  logic [2:0]    r_cand, w_cand;
  logic [3:0]    r_cnt, w_cnt;
  logic [3:0]    r_miss, w_miss;
  logic [2:0]    r_pos, w_pos;
  logic [PW-1:0] r_str, w_str;
  logic          w_evNew;
  logic [1:0]    w_evCode;
  logic [2:0]    w_evPos;
  logic [2:0]    w_diff;

  logic          r_evValid;
  logic [1:0]    r_evCode;
  logic [2:0]    r_evPos;
  logic          r_ovf;

  // Absolute difference of each adjacent pixel pair
  always_comb begin
    for (int i = 0; i < NG; i++) begin
      if (pixelsIn[(i+1)*PW +: PW] >= pixelsIn[i*PW +: PW])
        w_grad[i] = pixelsIn[(i+1)*PW +: PW] - pixelsIn[i*PW +: PW];
      else
        w_grad[i] = pixelsIn[i*PW +: PW] - pixelsIn[(i+1)*PW +: PW];
    end
  end

  // Stage 1 register: gradients and frame qualifier
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NG; i++) r_grad[i] <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      for (int i = 0; i < NG; i++) r_grad[i] <= w_grad[i];
      r_s1Valid <= pixelsValid;
    end
  end

  // Strongest gradient; strict compare keeps the lowest index on ties
  always_comb begin
    w_max = r_grad[0];
    w_idx = 3'd0;
    for (int i = 1; i < NG; i++) begin
      if (r_grad[i] > w_max) begin
        w_max = r_grad[i];
        w_idx = 3'(i);
      end
    end
  end

  // Stage 2 register: selection and threshold qualification
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_maxVal  <= '0;
      r_maxIdx  <= '0;
      r_hit     <= 1'b0;
      r_s2Valid <= 1'b0;
    end else begin
      r_maxVal  <= w_max;
      r_maxIdx  <= w_idx;
      r_hit     <= r_s1Valid && (w_max >= TH);
      r_s2Valid <= r_s1Valid;
    end
  end

  assign w_diff = (r_maxIdx > r_pos) ? (r_maxIdx - r_pos)
                                     : (r_pos - r_maxIdx);

  // Debounce FSM next state, counters and event generation
  always_comb begin
    w_state  = r_state;
    w_cand   = r_cand;
    w_cnt    = r_cnt;
    w_miss   = r_miss;
    w_pos    = r_pos;
    w_str    = r_str;
    w_evNew  = 1'b0;
    w_evCode = 2'd0;
    w_evPos  = 3'd0;
    if (r_s2Valid) begin
      unique case (r_state)
        S_SEARCH: begin
          if (r_hit) begin
            if (CONF <= 4'd1) begin
              w_state  = S_LOCKED;
              w_pos    = r_maxIdx;
              w_str    = r_maxVal;
              w_miss   = 4'd0;
              w_cnt    = 4'd0;
              w_evNew  = 1'b1;
              w_evCode = EV_LOCK;
              w_evPos  = r_maxIdx;
            end else begin
              w_state = S_CAND;
              w_cand  = r_maxIdx;
              w_cnt   = 4'd1;
            end
          end
        end
        S_CAND: begin
          if (r_hit && r_maxIdx == r_cand) begin
            if (r_cnt + 4'd1 >= CONF) begin
              w_state  = S_LOCKED;
              w_pos    = r_cand;
              w_str    = r_maxVal;
              w_miss   = 4'd0;
              w_cnt    = 4'd0;
              w_evNew  = 1'b1;
              w_evCode = EV_LOCK;
              w_evPos  = r_cand;
            end else begin
              w_cnt = r_cnt + 4'd1;
            end
          end else if (r_hit) begin
            w_cand = r_maxIdx;
            w_cnt  = 4'd1;
          end else begin
            w_state = S_SEARCH;
            w_cnt   = 4'd0;
          end
        end
        S_LOCKED: begin
          if (r_hit && r_maxIdx == r_pos) begin
            w_miss = 4'd0;
            w_str  = r_maxVal;
          end else if (r_hit && w_diff == 3'd1) begin
            w_pos    = r_maxIdx;
            w_str    = r_maxVal;
            w_miss   = 4'd0;
            w_evNew  = 1'b1;
            w_evCode = EV_MOVE;
            w_evPos  = r_maxIdx;
          end else if (r_miss + 4'd1 >= LOSS) begin
            w_state  = S_SEARCH;
            w_miss   = 4'd0;
            w_evNew  = 1'b1;
            w_evCode = EV_LOSS;
            w_evPos  = r_pos;
          end else begin
            w_miss = r_miss + 4'd1;
          end
        end
        default: w_state = S_SEARCH;
      endcase
    end
  end

  // Stage 3 register: FSM state and tracked edge
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_SEARCH;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_miss  <= '0;
      r_pos   <= '0;
      r_str   <= '0;
    end else begin
      r_state <= w_state;
      r_cand  <= w_cand;
      r_cnt   <= w_cnt;
      r_miss  <= w_miss;
      r_pos   <= w_pos;
      r_str   <= w_str;
    end
  end

  // One-entry event holding register; a full, unaccepted slot drops new events
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_evValid <= 1'b0;
      r_evCode  <= '0;
      r_evPos   <= '0;
      r_ovf     <= 1'b0;
    end else if (w_evNew) begin
      if (!r_evValid || eventReady) begin
        r_evValid <= 1'b1;
        r_evCode  <= w_evCode;
        r_evPos   <= w_evPos;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (r_evValid && eventReady) begin
      r_evValid <= 1'b0;
    end
  end

  assign edgeLocked    = (r_state == S_LOCKED);
  assign edgePosition  = r_pos;
  assign edgeStrength  = r_str;
  assign eventValid    = r_evValid;
  assign eventCode     = r_evCode;
  assign eventPos      = r_evPos;
  assign eventOverflow = r_ovf;

endmodule

// File: tb/tb_edge_tracker.sv
// Bench for edge_tracker: directed frames, expected events
// queued by the stimulus and checked by a handshake monitor.
module tb_edge_tracker;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [39:0] pixelsIn = '0;
  logic        pixelsValid = 1'b0;
  logic        edgeLocked;
  logic [2:0]  edgePosition;
  logic [7:0]  edgeStrength;
  logic        eventValid;
  logic [1:0]  eventCode;
  logic [2:0]  eventPos;
  logic        eventReady = 1'b0;
  logic        eventOverflow;

  int errors = 0;
  int checks = 0;
  logic [4:0] expq [$];

  edge_tracker dut (
    .clock        (clock),
    .resetN       (resetN),
    .pixelsIn     (pixelsIn),
    .pixelsValid  (pixelsValid),
    .edgeLocked   (edgeLocked),
    .edgePosition (edgePosition),
    .edgeStrength (edgeStrength),
    .eventValid   (eventValid),
    .eventCode    (eventCode),
    .eventPos     (eventPos),
    .eventReady   (eventReady),
    .eventOverflow(eventOverflow)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] pk(input logic [7:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [39:0] px, input logic v);
    pixelsIn = px;
    pixelsValid = v;
    @(posedge clock);
    #1;
    pixelsValid = 1'b0;
  endtask

  task automatic frames(input logic [39:0] px, input int n);
    for (int i = 0; i < n; i++) step(px, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  task automatic wait_lock(input string nm, input logic want);
    int k;
    k = 0;
    while (edgeLocked !== want && k < 8) begin
      idle(1);
      k++;
    end
    chk(nm, 32'(edgeLocked), 32'(want));
  endtask

  task automatic expect_ev(input logic [1:0] code, input logic [2:0] pos);
    expq.push_back({code, pos});
  endtask

  // Monitor: every accepted event must match the head of the queue
  always @(negedge clock) begin
    logic [4:0] e;
    if (resetN && eventValid && eventReady) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got code %0d pos %0d expected none",
                 eventCode, eventPos);
      end else begin
        e = expq.pop_front();
        if ({eventCode, eventPos} !== e) begin
          errors++;
          $display("FAIL event: got code %0d pos %0d expected code %0d pos %0d",
                   eventCode, eventPos, e[4:3], e[2:0]);
        end
      end
    end
  end

  logic [39:0] flat, fa, fb, ftie, f15, f16;

  initial begin
    flat = pk(10, 10, 10, 10, 10);
    fa   = pk(10, 10, 200, 200, 200);
    fb   = pk(10, 10, 10, 200, 200);
    ftie = pk(0, 50, 100, 100, 100);
    f15  = pk(0, 15, 15, 15, 15);
    f16  = pk(0, 16, 16, 16, 16);

    #12;
    chk("rst_locked", 32'(edgeLocked), 0);
    chk("rst_pos", 32'(edgePosition), 0);
    chk("rst_strength", 32'(edgeStrength), 0);
    chk("rst_evvalid", 32'(eventValid), 0);
    chk("rst_evcode", 32'(eventCode), 0);
    chk("rst_ovf", 32'(eventOverflow), 0);
    resetN = 1'b1;
    eventReady = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(flat, 1'b1);
      chk("flat_quiet", 32'({edgeLocked, eventValid}), 0);
    end
    idle(3);
    chk("flat_after", 32'({edgeLocked, eventValid}), 0);

    expect_ev(2'd1, 3'd1);
    frames(fa, 3);
    wait_lock("lock_a", 1'b1);
    chk("lock_a_pos", 32'(edgePosition), 1);
    chk("lock_a_str", 32'(edgeStrength), 190);

    expect_ev(2'd2, 3'd2);
    frames(fb, 1);
    idle(4);
    chk("move_pos", 32'(edgePosition), 2);
    chk("move_locked", 32'(edgeLocked), 1);
    expect_ev(2'd3, 3'd2);
    frames(flat, 4);
    wait_lock("loss_a", 1'b0);

    expect_ev(2'd1, 3'd0);
    frames(ftie, 3);
    wait_lock("lock_tie", 1'b1);
    chk("tie_pos", 32'(edgePosition), 0);
    chk("tie_str", 32'(edgeStrength), 50);

    expect_ev(2'd3, 3'd0);
    frames(f15, 4);
    wait_lock("th15_loss", 1'b0);
    expect_ev(2'd1, 3'd0);
    frames(f16, 3);
    wait_lock("th16_lock", 1'b1);
    chk("th16_str", 32'(edgeStrength), 16);
    expect_ev(2'd3, 3'd0);
    frames(flat, 4);
    wait_lock("th16_loss", 1'b0);
    idle(2);

    eventReady = 1'b0;
    expect_ev(2'd1, 3'd1);
    frames(fa, 3);
    wait_lock("ovf_lock", 1'b1);
    frames(fb, 1);
    idle(4);
    chk("ovf_flag", 32'(eventOverflow), 1);
    chk("ovf_held", 32'({eventValid, eventCode, eventPos}), 32'({1'b1, 2'd1, 3'd1}));
    chk("ovf_newpos", 32'(edgePosition), 2);
    eventReady = 1'b1;
    idle(1);
    chk("ovf_drain", 32'(eventValid), 0);
    expect_ev(2'd3, 3'd2);
    frames(flat, 4);
    wait_lock("ovf_loss", 1'b0);
    idle(3);

    frames(fa, 2);
    idle(2);
    resetN = 1'b0;
    #1;
    chk("midrst_ovf", 32'(eventOverflow), 0);
    chk("midrst_out", 32'({edgeLocked, edgePosition, edgeStrength, eventValid}), 0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    frames(fa, 2);
    idle(5);
    chk("postrst_nolock", 32'({edgeLocked, eventValid}), 0);
    expect_ev(2'd1, 3'd1);
    frames(fa, 1);
    wait_lock("gap_lock", 1'b1);
    idle(4);

    chk("events_drained", 32'(expq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
